// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_START  = 7;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] CNT_MID  = 4'(MID_START);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  // Odd mode: the total count of ones over data+parity must be odd.
  function automatic logic parity_err(input logic [7:0] d, input logic p, input logic odd);
    return ((^{d, p}) != odd);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return ((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx metastability synchronizer; with UART_RX_MAJORITY_EN defined, rx_smp is a 2-of-3 vote
// over the current and two previous synchronized samples.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_smp
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end

  // Preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  logic [1:0] hist_d;

  always_comb begin
    hist_d = {hist_q[0], rx_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rx_smp = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign rx_smp = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8-data/parity/stop frames into a hold register with flags.
// Optional 2-of-3 sample voting is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b1
) (
  input  logic       mclkx16,
  input  logic       reset,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] data,
  output logic       rxrdy,
  output logic       parityerr,
  output logic       framingerr,
  output logic       overrun
);

  logic rx_s;
  logic rx_smp;

  rx_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sr_q, sr_d;
  logic       pbit_q, pbit_d;
  logic [7:0] data_q, data_d;
  logic       rxrdy_q, rxrdy_d;
  logic       parityerr_q, parityerr_d;
  logic       framingerr_q, framingerr_d;
  logic       overrun_q, overrun_d;
  logic       tick_s;
  logic       load_s;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (mclkx16),
    .rst_n (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .rx_smp(rx_smp)
  );

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      bitcnt_q     <= 3'd0;
      sr_q         <= 8'h00;
      pbit_q       <= 1'b0;
      data_q       <= 8'h00;
      rxrdy_q      <= 1'b0;
      parityerr_q  <= 1'b0;
      framingerr_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      sr_q         <= sr_d;
      pbit_q       <= pbit_d;
      data_q       <= data_d;
      rxrdy_q      <= rxrdy_d;
      parityerr_q  <= parityerr_d;
      framingerr_q <= framingerr_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tick_s = (cnt_q == CNT_LAST);
  assign load_s = (state_q == STOP) && tick_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
        else       state_d = IDLE;
      end
      START: begin
        if (cnt_q == CNT_MID) state_d = rx_smp ? IDLE : DATA;
        else                  state_d = START;
      end
      DATA: begin
        if (tick_s && (bitcnt_q == BIT_LAST)) state_d = PARITY;
        else                                  state_d = DATA;
      end
      PARITY: begin
        if (tick_s) state_d = STOP;
        else        state_d = PARITY;
      end
      // A low stop bit parks in BREAK so a held-low line cannot start a new frame.
      STOP: begin
        if (tick_s) state_d = rx_smp ? IDLE : BREAK;
        else        state_d = STOP;
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
        else      state_d = BREAK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q + 4'd1;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    pbit_d   = pbit_q;
    case (state_q)
      IDLE: begin
        cnt_d    = 4'd0;
        bitcnt_d = 3'd0;
      end
      START: begin
        if (cnt_q == CNT_MID) cnt_d = 4'd0;
        else                  cnt_d = cnt_q + 4'd1;
      end
      DATA: begin
        if (tick_s) begin
          sr_d     = {rx_smp, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end else begin
          sr_d     = sr_q;
          bitcnt_d = bitcnt_q;
        end
      end
      PARITY: begin
        if (tick_s) pbit_d = rx_smp;
        else        pbit_d = pbit_q;
      end
      STOP:    cnt_d = cnt_q + 4'd1;
      BREAK:   cnt_d = cnt_q + 4'd1;
      default: cnt_d = 4'd0;
    endcase
  end

  // A load always lands; a same-cycle read only suppresses the overrun it would cause.
  always_comb begin
    data_d       = data_q;
    rxrdy_d      = rxrdy_q;
    parityerr_d  = parityerr_q;
    framingerr_d = framingerr_q;
    overrun_d    = overrun_q;
    if (load_s) begin
      data_d       = sr_q;
      parityerr_d  = parity_err(sr_q, pbit_q, PARITY_ODD);
      framingerr_d = ~rx_smp;
      rxrdy_d      = 1'b1;
      overrun_d    = (rxrdy_q & ~read) | (overrun_q & ~read);
    end else if (read) begin
      rxrdy_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      rxrdy_d   = rxrdy_q;
      overrun_d = overrun_q;
    end
  end

  assign data       = data_q;
  assign rxrdy      = rxrdy_q;
  assign parityerr  = parityerr_q;
  assign framingerr = framingerr_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table plus hand-written multi-cycle sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int SYNC = 2;

  logic       mclkx16 = 1'b0;
  logic       reset   = 1'b1;
  logic       rx      = 1'b1;
  logic       read    = 1'b0;
  logic [7:0] data;
  logic       rxrdy;
  logic       parityerr;
  logic       framingerr;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(
    .SYNC_STAGES(SYNC),
    .PARITY_ODD (1'b1)
  ) dut (
    .mclkx16   (mclkx16),
    .reset     (reset),
    .rx        (rx),
    .read      (read),
    .data      (data),
    .rxrdy     (rxrdy),
    .parityerr (parityerr),
    .framingerr(framingerr),
    .overrun   (overrun)
  );

  always #5 mclkx16 = ~mclkx16;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stp;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclkx16);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic do_read();
    read = 1'b1;
    tick(1);
    read = 1'b0;
  endtask

  // Frame start..stop, 16 cycles per bit; optional read pulse in the stop bit and
  // optional one-cycle inverted pulse at offset 8 of frame bit glitch_bit. Leaves rx at stop level.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                            input int read_at, input int glitch_bit);
    logic [10:0] bits;
    bits = {stp, p, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int i = 0; i < 16; i++) begin
        rx   = (b == glitch_bit && i == 8) ? ~bits[b] : bits[b];
        read = (b == 10 && i == read_at);
        @(posedge mclkx16);
        #1;
      end
    end
    read = 1'b0;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic check_byte(input string name, input logic [7:0] d, input logic rdy,
                            input logic pe, input logic fe, input logic ov);
    check({name, ".data"}, 32'(data), 32'(d));
    check({name, ".rxrdy"}, 32'(rxrdy), 32'(rdy));
    check({name, ".perr"}, 32'(parityerr), 32'(pe));
    check({name, ".ferr"}, 32'(framingerr), 32'(fe));
    check({name, ".ovr"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] pre;

    vecs[0] = '{d: 8'hA5, p: 1'b1, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{d: 8'h01, p: 1'b1, stp: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{d: 8'hFF, p: 1'b1, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{d: 8'h00, p: 1'b0, stp: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{d: 8'h80, p: 1'b0, stp: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[5] = '{d: 8'hC3, p: 1'b1, stp: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[6] = '{d: 8'h7F, p: 1'b1, stp: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};

    #3 reset = 1'b0;
    tick(3);
    check_byte("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    idle(4);

    // Start edge to rxrdy: SYNC stages + IDLE detect + 8 + 16*10 ticks.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
      begin
        while (!rxrdy && lat < 400) begin
          @(posedge mclkx16);
          #1;
          lat++;
        end
      end
    join
    check("latency", 32'(lat), 32'(SYNC + 169));
    check_byte("t1_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    idle(16);

    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].d, vecs[k].p, vecs[k].stp, -1, -1);
      idle(2);
      check_byte($sformatf("vec%0d", k), vecs[k].d, 1'b1, vecs[k].exp_perr, vecs[k].exp_ferr, 1'b0);
      do_read();
      check($sformatf("vec%0d.rdclr", k), 32'(rxrdy), 32'd0);
      check($sformatf("vec%0d.perr_keep", k), 32'(parityerr), 32'(vecs[k].exp_perr));
      idle(30);
    end

    // Framing error with a long break: exactly one load, then clean recovery.
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    rx = 1'b0;
    tick(640);
    check_byte("brk", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    check("brk.state", 32'(dut.state_q), 32'(BREAK));
    idle(32);
    check("brk.idle", 32'(dut.state_q), 32'(IDLE));
    do_read();
    send_frame(8'h55, 1'b1, 1'b1, -1, -1);
    idle(2);
    check_byte("brk_next", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    idle(16);

    // Overrun, read clearing, read with nothing pending.
    send_frame(8'h11, 1'b1, 1'b1, -1, -1);
    idle(8);
    send_frame(8'h22, 1'b1, 1'b1, -1, -1);
    idle(2);
    check_byte("ovr", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    do_read();
    check_byte("ovr_rd", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read();
    check_byte("idle_rd", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(16);

    // Read in the very cycle of the second load: load wins, no overrun.
    send_frame(8'h33, 1'b1, 1'b1, -1, -1);
    idle(8);
    send_frame(8'h44, 1'b1, 1'b1, 10, -1);
    idle(2);
    check_byte("ld_rd", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    idle(16);

    // Short low glitch on an idle line is rejected at the start mid-sample.
    rx = 1'b0;
    tick(3);
    idle(30);
    check("glitch.state", 32'(dut.state_q), 32'(IDLE));
    check("glitch.rxrdy", 32'(rxrdy), 32'd0);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hF0, 1'b1, 1'b1, -1, 6);
    idle(2);
    check_byte("maj_f0", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    idle(16);
`endif

    // Reset during data bit 4 of 0x99 with an unread, flagged byte in the hold register.
    send_frame(8'h81, 1'b0, 1'b1, -1, -1);
    idle(4);
    check_byte("pre_rst", 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    pre = 8'h99;
    rx = 1'b0;
    tick(16);
    for (int b = 0; b < 4; b++) begin
      rx = pre[b];
      tick(16);
    end
    rx = pre[4];
    tick(8);
    reset = 1'b0;
    #2;
    check_byte("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst.state", 32'(dut.state_q), 32'(IDLE));
    tick(3);
    reset = 1'b1;
    idle(20);
    send_frame(8'h7E, 1'b1, 1'b1, -1, -1);
    idle(2);
    check_byte("post_rst", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    idle(4);

    // Back-to-back frames as a transmitter would send them.
    for (int k = 0; k < 256; k++) begin
      send_frame(8'(k), odd_par(8'(k)), 1'b1, -1, -1);
      rx = 1'b1;
      check($sformatf("loop%0d", k), {19'd0, data, rxrdy, parityerr, framingerr, overrun},
            {19'd0, 8'(k), 1'b1, 1'b0, 1'b0, 1'b0});
      do_read();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
